// File: rtl/gauss_conv_sched.sv
// gauss_conv_sched: frame sequencer for the 5x5 Gaussian engine. It loads one
// 5-row band into the window buffer, kicks the engine, and stores the 28
// filtered pixels of that band. This repeats until every output row is written.
module gauss_conv_sched #(
    parameter int unsigned IMG_W    = 32,
    parameter int unsigned IMG_H    = 32,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned DST_BASE = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [5:0]        row_idx,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        conv_buf [0:IMG_W*5-1],
    output logic              conv_start,
    input  logic              conv_done,
    input  logic [7:0]        conv_result [0:IMG_W-5],
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    localparam int unsigned BAND_BYTES = IMG_W * 5;
    localparam int unsigned OUT_W      = IMG_W - 4;
    localparam int unsigned LAST_ROW   = IMG_H - 5;
    localparam int unsigned ROW_W      = 6;
    localparam int unsigned LOAD_W     = 8;
    localparam int unsigned COL_W      = 5;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        LOAD_LAST,
        START,
        WAIT_DONE,
        WAIT_CLR,
        STORE,
        NEXT,
        FIN
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic [ROW_W-1:0]    rowNext;
    logic [LOAD_W-1:0]   loadIdx;
    logic [LOAD_W-1:0]   loadNext;
    logic [COL_W-1:0]    colIdx;
    logic [COL_W-1:0]    colNext;

    logic                busyNext;
    logic                doneNext;
    logic                rdEnNext;
    logic [ADDR_W-1:0]   rdAddrNext;
    logic                convStartNext;
    logic                wrEnNext;
    logic [ADDR_W-1:0]   wrAddrNext;
    logic [7:0]          wrDataNext;

    // Next-state and counter sequencing; outputs are derived from the next
    // state so the registered strobes line up with the state they belong to.
    always_comb begin
        stateNext = state;
        rowNext   = row_idx;
        loadNext  = loadIdx;
        colNext   = colIdx;

        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = LOAD;
                    rowNext   = '0;
                    loadNext  = '0;
                end
            end
            LOAD: begin
                if (loadIdx == LOAD_W'(BAND_BYTES - 1)) begin
                    stateNext = LOAD_LAST;
                end else begin
                    loadNext = loadIdx + LOAD_W'(1);
                end
            end
            LOAD_LAST: stateNext = START;
            START:     stateNext = WAIT_DONE;
            WAIT_DONE: begin
                if (conv_done) begin
                    stateNext = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                // Engine re-samples start while idle, so let done drop first.
                if (!conv_done) begin
                    stateNext = STORE;
                    colNext   = '0;
                end
            end
            STORE: begin
                if (colIdx == COL_W'(OUT_W - 1)) begin
                    stateNext = NEXT;
                end else begin
                    colNext = colIdx + COL_W'(1);
                end
            end
            NEXT: begin
                if (row_idx == ROW_W'(LAST_ROW)) begin
                    stateNext = FIN;
                end else begin
                    stateNext = LOAD;
                    rowNext   = row_idx + ROW_W'(1);
                    loadNext  = '0;
                end
            end
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        busyNext      = (stateNext != IDLE) && (stateNext != FIN);
        doneNext      = (stateNext == FIN);
        convStartNext = (stateNext == START);

        rdEnNext   = (stateNext == LOAD);
        rdAddrNext = '0;
        if (rdEnNext) begin
            rdAddrNext = ADDR_W'(SRC_BASE) + ADDR_W'(rowNext) * ADDR_W'(IMG_W)
                       + ADDR_W'(loadNext);
        end

        wrEnNext   = (stateNext == STORE);
        wrAddrNext = '0;
        wrDataNext = '0;
        if (wrEnNext) begin
            wrAddrNext = ADDR_W'(DST_BASE) + ADDR_W'(rowNext) * ADDR_W'(OUT_W)
                       + ADDR_W'(colNext);
            wrDataNext = conv_result[colNext];
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            row_idx    <= '0;
            loadIdx    <= '0;
            colIdx     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            conv_start <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            state      <= stateNext;
            row_idx    <= rowNext;
            loadIdx    <= loadNext;
            colIdx     <= colNext;
            busy       <= busyNext;
            done       <= doneNext;
            rd_en      <= rdEnNext;
            rd_addr    <= rdAddrNext;
            conv_start <= convStartNext;
            wr_en      <= wrEnNext;
            wr_addr    <= wrAddrNext;
            wr_data    <= wrDataNext;
        end
    end

    // Window buffer capture: each byte lands one cycle after its read request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < BAND_BYTES; k++) begin
                conv_buf[k] <= '0;
            end
        end else if (state == LOAD && loadIdx != '0) begin
            conv_buf[loadIdx - LOAD_W'(1)] <= rd_data;
        end else if (state == LOAD_LAST) begin
            conv_buf[BAND_BYTES - 1] <= rd_data;
        end
    end

endmodule

// File: tb/tb_gauss_conv_sched.sv
// tb_gauss_conv_sched: directed vectors for the Gaussian band sequencer with a
// source memory, a 2-cycle-done engine model and a write/read monitor.
module tb_gauss_conv_sched;

    localparam int TB_H   = 8;
    localparam int BANDS  = TB_H - 4;
    localparam int NWR    = BANDS * 28;
    localparam int NRD    = BANDS * 160;
    localparam int DSTB   = 2048;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [5:0]  row_idx;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [7:0]  rd_data = 8'd0;
    logic [7:0]  convBuf [0:159];
    logic        conv_start;
    logic        conv_done;
    logic [7:0]  convResult [0:27];
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;

    gauss_conv_sched #(.IMG_H(TB_H)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .row_idx(row_idx), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .conv_buf(convBuf), .conv_start(conv_start), .conv_done(conv_done),
        .conv_result(convResult), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] srcMem [0:4095];
    logic [7:0] dstMem [0:4095];
    int checks   = 0;
    int failures = 0;
    int frameId  = 0;
    logic glitchReq = 1'b0;

    function automatic int kw(input int rr, input int cc);
        int k [25];
        k = '{2, 4, 5, 4, 2, 4, 9, 12, 9, 4, 5, 12, 15, 12, 5, 4, 9, 12, 9, 4, 2, 4, 5, 4, 2};
        return k[rr * 5 + cc];
    endfunction

    function automatic logic [7:0] gaussPix(input int s);
        return 8'((s >> 9) + (s >> 8));
    endfunction

    // Engine's view: window taken from the buffer the DUT drives.
    function automatic logic [7:0] engPix(input int c);
        int s = 0;
        for (int rr = 0; rr < 5; rr++)
            for (int cc = 0; cc < 5; cc++)
                s += int'(convBuf[rr * 32 + c + cc]) * kw(rr, cc);
        return gaussPix(s);
    endfunction

    // Reference: window taken straight from source memory.
    function automatic logic [7:0] modelPix(input int r, input int c);
        int s = 0;
        for (int rr = 0; rr < 5; rr++)
            for (int cc = 0; cc < 5; cc++)
                s += int'(srcMem[(r + rr) * 32 + c + cc]) * kw(rr, cc);
        return gaussPix(s);
    endfunction

    // Source memory: data one cycle after the request.
    always @(posedge clk) begin
        if (rd_en) rd_data <= srcMem[rd_addr];
    end

    // Engine model: result latched on start, done high for two cycles.
    int engCnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            engCnt    <= 0;
            conv_done <= 1'b0;
            for (int c = 0; c < 28; c++) convResult[c] <= 8'd0;
        end else begin
            conv_done <= glitchReq || engCnt == 1 || engCnt == 2;
            if (conv_start) begin
                engCnt <= 5;
                for (int c = 0; c < 28; c++) convResult[c] <= engPix(c);
            end else if (engCnt != 0) begin
                engCnt <= engCnt - 1;
            end
        end
    end

    // Per-frame monitor of reads, writes, engine handshake and done.
    int seenFrame = 0;
    int rdCnt, wrCnt, startCnt, doneCnt;
    int rdErr, wrErr, overlapErr, sdErr, doneBusyErr;
    always @(negedge clk) begin
        if (frameId != seenFrame) begin
            seenFrame = frameId;
            rdCnt = 0; wrCnt = 0; startCnt = 0; doneCnt = 0;
            rdErr = 0; wrErr = 0; overlapErr = 0; sdErr = 0; doneBusyErr = 0;
            for (int a = DSTB; a < DSTB + NWR; a++) dstMem[a] = 8'd0;
        end
        if (reset) begin
            if (rd_en && wr_en) overlapErr++;
            if (rd_en) begin
                if (int'(rd_addr) != (rdCnt / 160) * 32 + rdCnt % 160 ||
                    int'(row_idx) != rdCnt / 160) rdErr++;
                rdCnt++;
            end
            if (wr_en) begin
                dstMem[wr_addr] = wr_data;
                if (int'(wr_addr) != DSTB + wrCnt) wrErr++;
                wrCnt++;
            end
            if (conv_start) begin
                startCnt++;
                if (conv_done) sdErr++;
            end
            if (done) begin
                doneCnt++;
                if (busy) doneBusyErr++;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic fillFrame(input int kind, input int fillVal, input int impRow,
                             input int impCol, input int impVal);
        for (int y = 0; y < TB_H; y++)
            for (int x = 0; x < 32; x++)
                srcMem[y * 32 + x] = (kind == 0) ? 8'(fillVal) :
                                     (kind == 1) ? 8'(x) : 8'((x * 7 + y * 13) & 255);
        if (impRow >= 0) srcMem[impRow * 32 + impCol] = 8'(impVal);
    endtask

    task automatic pulseStart();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic runFrame(input string tag, input int probeAddr, input int probeExp,
                            input bit midStart, input bit doneStart, input bit glitch);
        int t;
        int mism;
        frameId++;
        pulseStart();
        if (glitch) begin
            t = 0;
            while (t < 20 && !rd_en) begin @(negedge clk); t++; end
            glitchReq = 1'b1;
            @(posedge clk); #1 glitchReq = 1'b0;
        end
        if (midStart) begin
            repeat (200) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        t = 0;
        while (t < 4000) begin
            @(negedge clk);
            if (done) break;
            t++;
        end
        chk({tag, "_done_seen"}, int'(done), 1);
        if (doneStart && done) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        repeat (20) @(negedge clk);
        mism = 0;
        for (int r = 0; r < BANDS; r++)
            for (int c = 0; c < 28; c++)
                if (dstMem[DSTB + r * 28 + c] != modelPix(r, c)) mism++;
        chk({tag, "_data_mismatches"}, mism, 0);
        chk({tag, "_probe"}, int'(dstMem[probeAddr]), probeExp);
        chk({tag, "_writes"}, wrCnt, NWR);
        chk({tag, "_reads"}, rdCnt, NRD);
        chk({tag, "_rd_addr_errs"}, rdErr, 0);
        chk({tag, "_wr_addr_errs"}, wrErr, 0);
        chk({tag, "_conv_starts"}, startCnt, BANDS);
        chk({tag, "_start_while_done"}, sdErr, 0);
        chk({tag, "_rd_wr_overlap"}, overlapErr, 0);
        chk({tag, "_done_pulses"}, doneCnt, 1);
        chk({tag, "_busy_in_done"}, doneBusyErr, 0);
        chk({tag, "_busy_after"}, int'(busy), 0);
    endtask

    typedef struct {
        int kind; int fillVal; int impRow; int impCol; int impVal;
        int probeAddr; int probeExp; bit midStart; bit doneStart; bit glitch;
    } vec_t;

    vec_t vecs [5];

    task automatic chkOutputsZero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_conv_start"}, int'(conv_start), 0);
        chk({tag, "_row_idx"}, int'(row_idx), 0);
        chk({tag, "_addrs_data"}, int'(rd_addr) + int'(wr_addr) + int'(wr_data), 0);
        chk({tag, "_conv_buf5"}, int'(convBuf[5]), 0);
    endtask

    initial begin
        int t;
        // kind, fill, impRow, impCol, impVal, probeAddr, probeExp, midStart, doneStart, glitch
        vecs[0] = '{0, 100, -1, 0, 0, 2048, 93, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{0, 0, 2, 2, 255, 2048, 21, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{0, 0, 7, 31, 200, 2159, 1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{0, 255, -1, 0, 0, 2100, 237, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1, 0, -1, 0, 0, 2075, 27, 1'b0, 1'b0, 1'b0};

        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chkOutputsZero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            fillFrame(vecs[v].kind, vecs[v].fillVal, vecs[v].impRow,
                      vecs[v].impCol, vecs[v].impVal);
            runFrame($sformatf("vec%0d", v), vecs[v].probeAddr, vecs[v].probeExp,
                     vecs[v].midStart, vecs[v].doneStart, vecs[v].glitch);
        end

        // Asynchronous reset in the middle of storing band 3, then a clean rerun.
        fillFrame(2, 0, -1, 0, 0);
        frameId++;
        pulseStart();
        t = 0;
        while (t < 4000) begin
            @(negedge clk);
            if (wr_en && row_idx == 6'd3) break;
            t++;
        end
        chk("midrst_reached_band3_store", int'(wr_en && row_idx == 6'd3), 1);
        #2 reset = 1'b0;
        #1 chkOutputsZero("midrst");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        runFrame("after_rst", DSTB, int'(modelPix(0, 0)), 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
